ahblite_arbiter: RTL and testbench
==================================

AHBLITE_ARBITER -- requirements
Module: ahblite_arbiter

Interface
REQ-001 Parameter MASTER, default 4, number of requesting AHB-Lite masters (2..16).
REQ-002 Parameter SEL_W, default $clog2(MASTER), width of master index outputs.
REQ-003 HCLK  input  1  bus clock; all state updates on rising edge.
REQ-004 HRESET  input  1  reset, synchronous, active-high.
REQ-005 mst_HTRANS_i  input  [MASTER][2]  per-master HTRANS.
REQ-006 mst_HBURST_i  input  [MASTER][3]  per-master HBURST.
REQ-007 mst_HMASTLOCK_i  input  [MASTER]  per-master lock request.
REQ-008 HREADY_i  input  1  HREADY returned from the selected slave.
REQ-009 addr_sel_o  output  SEL_W  index of address-phase owner; drives the interconnect address mux.
REQ-010 data_sel_o  output  SEL_W  index of data-phase owner; drives the HWDATA/HRDATA mux.
REQ-011 grant_o  output  [MASTER]  one-hot decode of addr_sel_o.
REQ-012 locked_o  output  1  locked sequence in progress.
REQ-013 mst_HREADYOUT_o  output  [MASTER]  per-master HREADY.

Function
REQ-014 Master m SHALL be requesting when mst_HTRANS_i[m] != IDLE(2'b00).
REQ-015 Owner beat counter (2 bits) SHALL clear on an accepted NONSEQ and increment on an accepted SEQ; a transfer is accepted when the owner drives NONSEQ/SEQ and HREADY_i=1.
REQ-016 FSM SHALL have states PARK (owner not in a burst), BURST (fixed or INCR burst in progress), LOCK (locked sequence).
REQ-017 PARK->BURST on accepted owner NONSEQ with HBURST != SINGLE; PARK->LOCK on any accepted owner transfer with HMASTLOCK=1.
REQ-018 BURST->PARK when HREADY_i=1 and either: INCR4/WRAP4 with beat counter=3 on accepted SEQ, or INCR with owner HTRANS=IDLE or NONSEQ.
REQ-019 LOCK->PARK when HREADY_i=1 and owner HMASTLOCK=0 or owner HTRANS=IDLE; LOCK SHALL take priority over BURST.
REQ-020 Re-arbitration SHALL occur only on a cycle with HREADY_i=1 where the FSM is in PARK (after the above transitions) and the owner is not starting a burst or lock that cycle, or where the owner issues an accepted SINGLE NONSEQ without lock.
REQ-021 Arbitration SHALL be round-robin: winner is the first requesting master after rr_ptr cyclically (rr_ptr+1 ... rr_ptr); rr_ptr SHALL update to the winner.
REQ-022 If no master requests, addr_sel_o SHALL hold (bus parked on last owner).
REQ-023 A new grant SHALL take effect on addr_sel_o at the clock edge ending the arbitration cycle (1-cycle latency); grant_o SHALL always be one-hot.
REQ-024 data_sel_o SHALL load addr_sel_o on every edge with HREADY_i=1 and hold otherwise.
REQ-025 mst_HREADYOUT_o[m] SHALL equal HREADY_i if m==addr_sel_o or m==data_sel_o, else NOT(requesting m), combinationally.
REQ-026 HREADY_i=0 SHALL freeze FSM, counter, rr_ptr, addr_sel_o and data_sel_o.
REQ-027 Owner BUSY SHALL not advance the beat counter and SHALL not end BURST.
REQ-028 A BURST owner issuing NONSEQ mid-burst (early termination) SHALL restart the counter and remain owner.

Reset
REQ-029 With HRESET=1 at an edge: addr_sel_o=0, data_sel_o=0, grant_o=1, locked_o=0, FSM=PARK, beat counter=0, rr_ptr=MASTER-1.
REQ-030 HRESET asserted mid-burst or mid-lock SHALL abandon the sequence and apply REQ-029 the next edge; mst_HREADYOUT_o follows REQ-025 from reset values.
REQ-031 locked_o SHALL be 1 exactly when FSM=LOCK.

Verification
REQ-032 After reset, masters 1 and 2 drive NONSEQ SINGLE, HREADY_i=1 -> addr_sel_o=1 next cycle, then 2, then 1; HREADYOUT of waiting master = 0.
REQ-033 Master 0 INCR4 (NONSEQ+3 SEQ), master 3 requesting throughout -> addr_sel_o stays 0 for 4 accepted beats, switches to 3 on edge after beat 4.
REQ-034 Master 1 INCR4 with HREADY_i=0 for 2 cycles on beat 2 -> counter, addr_sel_o, data_sel_o frozen; handover still after 4th accepted beat.
REQ-035 Master 2 locked SINGLE x3 (HMASTLOCK=1), master 0 requesting -> locked_o=1, no handover until master 2 drops HMASTLOCK; then addr_sel_o=0.
REQ-036 No requests for 5 cycles after owner=3 -> addr_sel_o stays 3; data_sel_o=3; all non-owner HREADYOUT=1.
REQ-037 HRESET pulsed during master 1 WRAP4 beat 2 -> next cycle addr_sel_o=0, locked_o=0, counter=0, FSM=PARK.

Source files
------------

// File: rtl/ahblite_arbiter.sv
// Round-robin AHB-Lite bus arbiter. It grants the address phase to one master
// and keeps that grant for the whole of a fixed or INCR burst, or a locked sequence.
module ahblite_arbiter #(
  parameter int MASTER = 4,
  parameter int SEL_W  = $clog2(MASTER)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [MASTER-1:0][1:0] mst_HTRANS_i,
  input  logic [MASTER-1:0][2:0] mst_HBURST_i,
  input  logic [MASTER-1:0]      mst_HMASTLOCK_i,
  input  logic                   HREADY_i,
  output logic [SEL_W-1:0]       addr_sel_o,
  output logic [SEL_W-1:0]       data_sel_o,
  output logic [MASTER-1:0]      grant_o,
  output logic                   locked_o,
  output logic [MASTER-1:0]      mst_HREADYOUT_o
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t            state_q, state_d, park_next;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0]  rr_ptr_q;
  logic [MASTER-1:0] requesting;
  logic [1:0]        owner_trans;
  logic [2:0]        owner_burst;
  logic              owner_lock;
  logic              accepted, acc_nonseq, acc_seq;
  logic              fixed4, burst_end, rearb;
  logic              win_found;
  logic [SEL_W-1:0]  win_idx, cand;

  always_comb begin
    for (int m = 0; m < MASTER; m++) begin
      requesting[m] = (mst_HTRANS_i[m] != TRANS_IDLE);
    end
  end

  assign owner_trans = mst_HTRANS_i[addr_sel_o];
  assign owner_burst = mst_HBURST_i[addr_sel_o];
  assign owner_lock  = mst_HMASTLOCK_i[addr_sel_o];

  assign acc_nonseq  = HREADY_i && (owner_trans == TRANS_NONSEQ);
  assign acc_seq     = HREADY_i && (owner_trans == TRANS_SEQ);
  assign accepted    = acc_nonseq || acc_seq;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (acc_nonseq)   beat_cnt_d = 2'd0;
    else if (acc_seq) beat_cnt_d = beat_cnt_q + 2'd1;
  end

  // A four-beat burst ends when its fourth beat is accepted. At that point the
  // updated count (NONSEQ = 0, then one more for each SEQ) reaches 3.
  assign fixed4    = (owner_burst == BURST_INCR4) || (owner_burst == BURST_WRAP4);
  assign burst_end = fixed4 ? (acc_seq && beat_cnt_d == 2'd3)
                            : (HREADY_i && (owner_trans == TRANS_IDLE ||
                                            owner_trans == TRANS_NONSEQ));

  // This is the state the owner's current beat would select if no sequence were
  // open. Every exit from BURST or LOCK goes through it, so a NONSEQ that ends
  // one sequence can start the next one in the same cycle.
  always_comb begin
    park_next = PARK;
    if (accepted && owner_lock)                          park_next = LOCK;
    else if (acc_nonseq && owner_burst != BURST_SINGLE)  park_next = BURST;
  end

  // NOTE: every signal written in an always_comb gets a default first. Without
  // it, a path that skips the assignment makes synthesis infer a latch.
  always_comb begin
    state_d = state_q;
    if (HREADY_i) begin
      unique case (state_q)
        PARK:    state_d = park_next;
        BURST:   if ((accepted && owner_lock) || burst_end || acc_nonseq)
                   state_d = park_next;
        LOCK:    if (!owner_lock || owner_trans == TRANS_IDLE)
                   state_d = park_next;
        default: state_d = PARK;
      endcase
    end
  end

  assign rearb = HREADY_i && (state_d == PARK);

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int i = 1; i <= MASTER; i++) begin
      cand = SEL_W'((int'(rr_ptr_q) + i) % MASTER);
      if (!win_found && requesting[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever order the statements
  // are written in.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= PARK;
      beat_cnt_q <= 2'd0;
      rr_ptr_q   <= SEL_W'(MASTER - 1);
      addr_sel_o <= '0;
      data_sel_o <= '0;
    end else if (HREADY_i) begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_sel_o <= addr_sel_o;
      if (rearb && win_found) begin
        addr_sel_o <= win_idx;
        rr_ptr_q   <= win_idx;
      end
    end
  end

  assign locked_o = (state_q == LOCK);

  always_comb begin
    grant_o             = '0;
    grant_o[addr_sel_o] = 1'b1;
  end

  // Masters that own neither phase are stalled only while they are requesting.
  always_comb begin
    for (int m = 0; m < MASTER; m++) begin
      if (addr_sel_o == SEL_W'(m) || data_sel_o == SEL_W'(m))
        mst_HREADYOUT_o[m] = HREADY_i;
      else
        mst_HREADYOUT_o[m] = !requesting[m];
    end
  end

endmodule

// File: tb/tb_ahblite_arbiter.sv
// Directed bench for ahblite_arbiter with four masters: round-robin order,
// burst hold with wait states, locked sequences, parking and reset.
module tb_ahblite_arbiter;

  localparam int MASTER = 4;
  localparam int SEL_W  = 2;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, WRAP4 = 3'b010, INCR4 = 3'b011;

  logic                   hclk = 1'b0;
  logic                   hreset;
  logic [MASTER-1:0][1:0] htrans;
  logic [MASTER-1:0][2:0] hburst;
  logic [MASTER-1:0]      hlock;
  logic                   hready;
  logic [SEL_W-1:0]       addr_sel, data_sel;
  logic [MASTER-1:0]      grant, hreadyout;
  logic                   locked;

  int n_tests = 0;
  int n_fail  = 0;

  ahblite_arbiter #(.MASTER(MASTER), .SEL_W(SEL_W)) dut (
    .HCLK            (hclk),
    .HRESET          (hreset),
    .mst_HTRANS_i    (htrans),
    .mst_HBURST_i    (hburst),
    .mst_HMASTLOCK_i (hlock),
    .HREADY_i        (hready),
    .addr_sel_o      (addr_sel),
    .data_sel_o      (data_sel),
    .grant_o         (grant),
    .locked_o        (locked),
    .mst_HREADYOUT_o (hreadyout)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(input int m, input logic [1:0] t, input logic [2:0] b, input logic l);
    htrans[m] = t;
    hburst[m] = b;
    hlock[m]  = l;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    hreset = 1'b1;
    hready = 1'b1;
    htrans = '0;
    hburst = '0;
    hlock  = '0;
    tick();
    tick();
    check("rst_addr_sel", 32'(addr_sel), 0);
    check("rst_data_sel", 32'(data_sel), 0);
    check("rst_grant", 32'(grant), 32'h1);
    check("rst_locked", 32'(locked), 0);
    check("rst_hreadyout", 32'(hreadyout), 32'hf);

    // Round robin between two masters issuing single transfers
    hreset = 1'b0;
    drv(1, NONSEQ, SINGLE, 1'b0);
    drv(2, NONSEQ, SINGLE, 1'b0);
    #1;
    check("rr_hreadyout_pre", 32'(hreadyout), 32'b1001);
    tick();
    check("rr_addr_1", 32'(addr_sel), 1);
    check("rr_grant_1", 32'(grant), 32'b0010);
    check("rr_data_0", 32'(data_sel), 0);
    check("rr_waiting_ready", 32'(hreadyout), 32'b1011);
    tick();
    check("rr_addr_2", 32'(addr_sel), 2);
    check("rr_data_1", 32'(data_sel), 1);
    tick();
    check("rr_addr_1b", 32'(addr_sel), 1);
    check("rr_data_2", 32'(data_sel), 2);

    // Master 0 INCR4 while master 3 keeps requesting
    drv(1, IDLE, SINGLE, 1'b0);
    drv(2, IDLE, SINGLE, 1'b0);
    drv(0, NONSEQ, INCR4, 1'b0);
    tick();
    check("b0_grant_addr", 32'(addr_sel), 0);
    drv(3, NONSEQ, SINGLE, 1'b0);
    tick();
    check("b0_beat1_addr", 32'(addr_sel), 0);
    drv(0, SEQ, INCR4, 1'b0);
    #1;
    check("b0_m3_stalled", 32'(hreadyout), 32'b0111);
    tick();
    check("b0_beat2_addr", 32'(addr_sel), 0);
    check("b0_not_locked", 32'(locked), 0);
    tick();
    check("b0_beat3_addr", 32'(addr_sel), 0);
    tick();
    check("b0_handover_addr", 32'(addr_sel), 3);
    check("b0_handover_grant", 32'(grant), 32'b1000);
    check("b0_handover_data", 32'(data_sel), 0);

    // No requests: the bus stays parked on master 3
    drv(0, IDLE, SINGLE, 1'b0);
    drv(3, IDLE, SINGLE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("park_addr", 32'(addr_sel), 3);
    end
    check("park_data", 32'(data_sel), 3);
    check("park_hreadyout", 32'(hreadyout), 32'hf);

    // Master 1 INCR4 with two wait states on beat 2; master 2 waiting
    drv(1, NONSEQ, INCR4, 1'b0);
    tick();
    check("w1_grant_addr", 32'(addr_sel), 1);
    drv(2, NONSEQ, SINGLE, 1'b0);
    tick();
    check("w1_beat1_addr", 32'(addr_sel), 1);
    drv(1, SEQ, INCR4, 1'b0);
    hready = 1'b0;
    #1;
    check("w1_wait_hreadyout", 32'(hreadyout), 32'b1001);
    tick();
    check("w1_wait1_addr", 32'(addr_sel), 1);
    tick();
    check("w1_wait2_addr", 32'(addr_sel), 1);
    check("w1_wait2_data", 32'(data_sel), 1);
    hready = 1'b1;
    tick();
    check("w1_beat2_addr", 32'(addr_sel), 1);
    tick();
    check("w1_beat3_addr", 32'(addr_sel), 1);
    tick();
    check("w1_handover_addr", 32'(addr_sel), 2);
    check("w1_handover_data", 32'(data_sel), 1);

    // Master 2 runs locked singles while master 0 requests; one wait cycle first
    drv(1, IDLE, SINGLE, 1'b0);
    drv(2, NONSEQ, SINGLE, 1'b1);
    drv(0, NONSEQ, SINGLE, 1'b0);
    hready = 1'b0;
    tick();
    check("frz_data_sel", 32'(data_sel), 1);
    check("frz_addr_sel", 32'(addr_sel), 2);
    check("frz_not_locked", 32'(locked), 0);
    hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lk_addr", 32'(addr_sel), 2);
      check("lk_locked", 32'(locked), 1);
    end
    drv(2, IDLE, SINGLE, 1'b0);
    tick();
    check("lk_release_addr", 32'(addr_sel), 0);
    check("lk_release_locked", 32'(locked), 0);

    // Reset during beat 2 of a master 1 WRAP4 burst
    drv(0, IDLE, SINGLE, 1'b0);
    drv(1, NONSEQ, WRAP4, 1'b0);
    tick();
    check("rb_grant_addr", 32'(addr_sel), 1);
    tick();
    check("rb_beat1_addr", 32'(addr_sel), 1);
    drv(1, SEQ, WRAP4, 1'b0);
    hreset = 1'b1;
    tick();
    check("rb_addr_sel", 32'(addr_sel), 0);
    check("rb_data_sel", 32'(data_sel), 0);
    check("rb_locked", 32'(locked), 0);
    check("rb_grant", 32'(grant), 32'h1);
    hreset = 1'b0;
    drv(1, IDLE, SINGLE, 1'b0);
    drv(0, NONSEQ, SINGLE, 1'b0);
    drv(2, NONSEQ, SINGLE, 1'b0);
    tick();
    check("rb_rr_restart", 32'(addr_sel), 0);
    tick();
    check("rb_rr_next", 32'(addr_sel), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
